// File: rtl/cache_cmd_sequencer.sv
// Trace command sequencer: lookup, victim writeback, line fill,
// cache clear and saturating read/write/hit/miss statistics.
package mypkg;
  localparam int OFFSET_BITS = 6;
endpackage

module cache_cmd_sequencer
  import mypkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32,
  parameter int OFF_W  = OFFSET_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_code,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              lk_req,
  output logic [ADDR_W-1:0] lk_addr,
  output logic              lk_write,
  output logic              lk_snoop,
  input  logic              lk_done,
  input  logic              lk_hit,
  input  logic              lk_victim_dirty,
  input  logic [ADDR_W-1:0] lk_victim_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              fill_en,
  output logic              clr_en,
  output logic              dump_pulse,
  output logic              bad_cmd,
  output logic              busy,
  output logic [CNT_W-1:0]  stat_reads,
  output logic [CNT_W-1:0]  stat_writes,
  output logic [CNT_W-1:0]  stat_hits,
  output logic [CNT_W-1:0]  stat_misses
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB, FILL, INSTALL, CLEAR
  } state_t;

  localparam logic [ADDR_W-1:0] LINE_MASK =
    {ADDR_W{1'b1}} << OFF_W;

  state_t state, state_nx;

  logic [ADDR_W-1:0] lat_addr, vic_addr;
  logic lat_write, lat_snoop;
  logic accept;
  logic is_rd, is_wr, is_sn, is_clr, is_dump;
  logic lk_fin, lk_miss;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  assign accept = cmd_valid && cmd_ready;
  assign lk_fin = (state == LOOKUP) && lk_done;
  assign lk_miss = lk_fin && !lat_snoop && !lk_hit;

  always_comb begin
    is_rd   = 1'b0;
    is_wr   = 1'b0;
    is_sn   = 1'b0;
    is_clr  = 1'b0;
    is_dump = 1'b0;
    unique case (1'b1)
      cmd_code == 4'd0,
      cmd_code == 4'd2: is_rd = 1'b1;
      cmd_code == 4'd1: is_wr = 1'b1;
      cmd_code >= 4'd3 && cmd_code <= 4'd6: is_sn = 1'b1;
      cmd_code == 4'd8: is_clr = 1'b1;
      cmd_code == 4'd9: is_dump = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    lk_req    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    fill_en   = 1'b0;
    clr_en    = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (accept) begin
          if (is_rd || is_wr || is_sn) state_nx = LOOKUP;
          else if (is_clr)             state_nx = CLEAR;
        end
      end
      LOOKUP: begin
        lk_req = 1'b1;
        if (lk_done) begin
          if (lat_snoop || lk_hit)  state_nx = IDLE;
          else if (lk_victim_dirty) state_nx = WB;
          else                      state_nx = FILL;
        end
      end
      WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = vic_addr & LINE_MASK;
        if (mem_ack) state_nx = FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = lat_addr & LINE_MASK;
        if (mem_ack) state_nx = INSTALL;
      end
      INSTALL: begin
        fill_en  = 1'b1;
        state_nx = IDLE;
      end
      CLEAR: begin
        clr_en   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign lk_addr  = lat_addr;
  assign lk_write = (state == LOOKUP) && lat_write;
  assign lk_snoop = (state == LOOKUP) && lat_snoop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr   <= '0;
      vic_addr   <= '0;
      lat_write  <= 1'b0;
      lat_snoop  <= 1'b0;
      dump_pulse <= 1'b0;
      bad_cmd    <= 1'b0;
    end else begin
      dump_pulse <= accept && is_dump;
      bad_cmd    <= accept && !(is_rd || is_wr || is_sn
                                || is_clr || is_dump);
      if (accept) begin
        lat_addr  <= cmd_addr;
        lat_write <= is_wr;
        lat_snoop <= is_sn;
      end
      if (lk_miss && lk_victim_dirty) vic_addr <= lk_victim_addr;
    end
  end

  // Clear wins over any increment; nothing else can be pending then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == CLEAR) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (accept && is_rd) stat_reads  <= sat_inc(stat_reads);
      if (accept && is_wr) stat_writes <= sat_inc(stat_writes);
      if (lk_fin && !lat_snoop && lk_hit)
        stat_hits <= sat_inc(stat_hits);
      if (lk_miss) stat_misses <= sat_inc(stat_misses);
    end
  end

endmodule
